// File: rtl/cache_fill_fsm.sv
// Block-fill sequencer shared by the I- and D-caches.
// Streams one aligned block from main memory into the missing cache.
module cache_fill_fsm #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    output logic        i_stall,
    output logic        d_stall,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic        fill_we,
    output logic        fill_sel,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        fill_last
);

    localparam int AW = $clog2(BLOCK_WORDS);
    localparam int CW = AW + 1;
    localparam int FW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [15:0]   LOW_MASK = 16'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_FLUSH,
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_issue_cnt;
    logic [CW-1:0]   r_recv_cnt;
    logic [15:0]     r_base;
    logic            r_sel;
    logic [FW-1:0]   r_flush_cnt;

    logic            w_fetch;
    logic            w_issue;
    logic            w_fill;
    logic            w_last;
    logic            w_flush_done;
    logic            w_busy;
    logic [15:0]     w_issue_addr;
    logic [15:0]     w_fill_addr;

    assign w_fetch      = (r_state == S_FETCH);
    assign w_issue      = w_fetch && (r_issue_cnt != CNT_FULL);
    assign w_fill       = w_fetch && mem_data_valid
                          && (r_recv_cnt != CNT_FULL);
    assign w_last       = w_fill && (r_recv_cnt == CNT_LAST);
    assign w_flush_done = (int'(r_flush_cnt) + 1) >= MEM_LATENCY;

    // Base is block aligned, so OR-ing the offset can never carry.
    assign w_issue_addr = r_base | 16'(r_issue_cnt[AW-1:0]);
    assign w_fill_addr  = r_base | 16'(r_recv_cnt[AW-1:0]);

    // Reset masks the fill-owner term so only the raw misses stall.
    assign w_busy   = !rst && (r_state != S_IDLE);
    assign i_stall  = i_miss | (w_busy & ~r_sel);
    assign d_stall  = d_miss | (w_busy & r_sel);

    assign mem_en    = w_issue;
    assign mem_addr  = w_issue ? w_issue_addr : '0;
    assign fill_we   = w_fill;
    assign fill_last = w_last;
    assign fill_sel  = w_fill & r_sel;
    assign fill_addr = w_fill ? w_fill_addr : '0;
    assign fill_data = w_fill ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FLUSH;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_base      <= '0;
            r_sel       <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                S_FLUSH: begin
                    if (w_flush_done) begin
                        r_state     <= S_IDLE;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    r_issue_cnt <= '0;
                    r_recv_cnt  <= '0;
                    if (d_miss) begin
                        r_base  <= d_miss_addr & ~LOW_MASK;
                        r_sel   <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (i_miss) begin
                        r_base  <= i_miss_addr & ~LOW_MASK;
                        r_sel   <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    if (w_fill) begin
                        r_recv_cnt <= r_recv_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed scenarios plus random traffic,
// checked against a transaction-level model of the block fill.
module tb_cache_fill_fsm;

    localparam int L   = 4;
    localparam int BW  = 8;
    localparam int INF = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_miss_addr;
    logic        d_miss;
    logic [15:0] d_miss_addr;
    logic        i_stall;
    logic        d_stall;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic        fill_we;
    logic        fill_sel;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        fill_last;

    cache_fill_fsm #(
        .MEM_LATENCY (L),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .i_stall        (i_stall),
        .d_stall        (d_stall),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_rdata      (mem_rdata),
        .fill_we        (fill_we),
        .fill_sel       (fill_sel),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .fill_last      (fill_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Fill transaction model: owner, base, start cycle, words received.
    bit          m_busy;
    bit          m_sel;
    int          m_start;
    int          m_got;
    int          m_ready;
    logic [15:0] m_base;

    bit          rsp_v [int];
    logic [15:0] rsp_d [int];

    int          st_fwe;
    int          st_first_men;
    int          st_flast;
    logic [15:0] st_amin;
    logic [15:0] st_amax;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)",
                   tag, obs, exp, n);
        end
    endtask

    task automatic stats_clear();
        st_fwe       = 0;
        st_first_men = -1;
        st_flast     = -1;
        st_amin      = 16'hffff;
        st_amax      = 16'h0000;
    endtask

    task automatic cyc(input logic r, input logic im,
                       input logic [15:0] ia, input logic dm,
                       input logic [15:0] da);
        bit          e_idle;
        bit          e_men;
        bit          e_fetch;
        bit          e_fwe;
        bit          e_flast;
        bit          e_ist;
        bit          e_dst;
        int          off;
        logic [15:0] e_maddr;
        logic [15:0] e_faddr;
        @(posedge clk);
        #1;
        rst         = r;
        i_miss      = im;
        i_miss_addr = ia;
        d_miss      = dm;
        d_miss_addr = da;
        e_fetch = !r && m_busy && (m_got < BW);
        if (rsp_v.exists(n)) begin
            mem_data_valid = 1'b1;
            mem_rdata      = rsp_d[n];
            rsp_v.delete(n);
            rsp_d.delete(n);
        end else begin
            mem_data_valid = !e_fetch && ($urandom_range(3) == 0);
            mem_rdata      = 16'($urandom);
        end
        #1;
        e_idle  = !r && (n >= m_ready) && !m_busy;
        off     = n - m_start;
        e_men   = !r && m_busy && (off >= 1) && (off <= BW);
        e_maddr = m_base + 16'(off - 1);
        e_fwe   = e_fetch && mem_data_valid;
        e_faddr = m_base + 16'(m_got);
        e_flast = e_fwe && (m_got == BW - 1);
        e_ist   = im | (!r && !e_idle && !m_sel);
        e_dst   = dm | (!r && !e_idle && m_sel);
        chk("i_stall", 16'(i_stall), 16'(e_ist));
        chk("d_stall", 16'(d_stall), 16'(e_dst));
        chk("mem_en", 16'(mem_en), 16'(e_men));
        chk("fill_we", 16'(fill_we), 16'(e_fwe));
        chk("fill_last", 16'(fill_last), 16'(e_flast));
        if (e_men) chk("mem_addr", mem_addr, e_maddr);
        if (e_fwe) begin
            chk("fill_addr", fill_addr, e_faddr);
            chk("fill_data", fill_data, mem_rdata);
            chk("fill_sel", 16'(fill_sel), 16'(m_sel));
        end
        if (fill_we === 1'b1) begin
            st_fwe++;
            if (fill_addr < st_amin) st_amin = fill_addr;
            if (fill_addr > st_amax) st_amax = fill_addr;
        end
        if (mem_en === 1'b1 && st_first_men < 0) st_first_men = n;
        if (fill_last === 1'b1) st_flast = n;
        if (mem_en === 1'b1) begin
            rsp_v[n + L] = 1'b1;
            rsp_d[n + L] = 16'($urandom);
        end
        if (r) begin
            m_busy  = 1'b0;
            m_sel   = 1'b0;
            m_base  = '0;
            m_got   = 0;
            m_ready = INF;
        end else begin
            if (m_ready == INF) m_ready = n + L;
            if (e_idle && (dm || im)) begin
                m_busy  = 1'b1;
                m_start = n;
                m_sel   = dm;
                m_base  = (dm ? da : ia) & ~16'(BW - 1);
                m_got   = 0;
            end else if (m_busy && m_got == BW) begin
                m_busy = 1'b0;
            end else if (e_fwe) begin
                m_got++;
            end
        end
        n++;
    endtask

    initial begin
        int n0;
        rst            = 1'b1;
        i_miss         = 1'b0;
        i_miss_addr    = '0;
        d_miss         = 1'b0;
        d_miss_addr    = '0;
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
        m_busy  = 1'b0;
        m_sel   = 1'b0;
        m_base  = '0;
        m_got   = 0;
        m_start = 0;
        m_ready = INF;
        stats_clear();

        repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_fill_addr", fill_addr, 16'h0000);
        repeat (L + 2) cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

        // I miss at 0x0013, dropped once the block is written
        stats_clear();
        n0 = n;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, k <= 12, 16'h0013, 1'b0, 16'h0);
            if (k == 14) chk("i_stall_after_fill", 16'(i_stall), 16'h0);
        end
        chk("first_men_cycle", 16'(st_first_men - n0), 16'd1);
        chk("fill_count", 16'(st_fwe), 16'd8);
        chk("fill_last_cycle", 16'(st_flast - n0), 16'd12);

        // I and D miss together: D first, then I
        stats_clear();
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, k <= 26, 16'h1234, k <= 12, 16'h0ABC);
            if (k >= 1 && k <= 13)
                chk("both_stall", 16'({i_stall, d_stall}), 16'h3);
            if (k == 5) begin
                chk("d_first_sel", 16'(fill_sel), 16'h1);
                chk("d_first_addr", fill_addr, 16'h0AB8);
            end
            if (k == 15) begin
                chk("i_next_en", 16'(mem_en), 16'h1);
                chk("i_next_addr", mem_addr, 16'h1230);
            end
        end

        // Top-of-memory block: no wrap
        stats_clear();
        for (int k = 0; k < 16; k++)
            cyc(1'b0, 1'b0, 16'h0, k <= 12, 16'hFFFC);
        chk("top_amin", st_amin, 16'hFFF8);
        chk("top_amax", st_amax, 16'hFFFF);
        chk("top_count", 16'(st_fwe), 16'd8);

        // Reset on cycle 6 of a fill, stale data during flush
        for (int k = 0; k < 6; k++)
            cyc(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0040, 1'b0, 16'h0);
        st_fwe = 0;
        for (int k = 0; k < 7; k++)
            cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("no_fill_after_rst", 16'(st_fwe), 16'd0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, k <= 12, 16'h0045, 1'b0, 16'h0);
            if (k == 1) begin
                chk("rst_refill_en", 16'(mem_en), 16'h1);
                chk("rst_refill_addr", mem_addr, 16'h0040);
            end
        end

        // Miss dropped on cycle 3: fill still completes
        stats_clear();
        n0 = n;
        for (int k = 0; k < 16; k++)
            cyc(1'b0, k <= 2, 16'h0100, 1'b0, 16'h0);
        chk("drop_count", 16'(st_fwe), 16'd8);
        chk("drop_last", 16'(st_flast - n0), 16'd12);

        // Random misses, addresses and occasional resets
        for (int k = 0; k < 800; k++)
            cyc($urandom_range(199) == 0, $urandom_range(3) == 0,
                16'($urandom), $urandom_range(4) == 0, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
